// File: rtl/m_freq_meter_if.sv
// Processor read-port bus for m_freq_meter: address, read strobe and
// registered read data.
interface m_freq_meter_if;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] in_port;

  // Processor side drives address and strobe, samples read data
  modport master (output port_id, output read_strobe, input in_port);
  // Peripheral side decodes address and strobe, returns read data
  modport slave (input port_id, input read_strobe, output in_port);
endinterface

// File: rtl/m_freq_meter.sv
// m_freq_meter: counts rising edges of an asynchronous SIGNAL over a gate
// window of GATE_CYCLES clocks and exposes the latched count byte-wise on
// the processor read port at BASE..BASE+3.
// Optional interrupt output is enabled with `define M_FREQ_METER_IRQ_EN.
module m_freq_meter #(
  parameter logic [7:0]  BASE        = 8'h00,
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH   = 24
) (
  input  logic          clk,
  input  logic          reset,
  m_freq_meter_if.slave bus,
  input  logic          SIGNAL,
  input  logic          ENABLE
`ifdef M_FREQ_METER_IRQ_EN
  ,
  output logic          INTERRUPT,
  input  logic          interrupt_ack
`endif
);

  localparam int unsigned         TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_GATE} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, hist_q;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] result_q, result_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 ovf_q, ovf_d;
  logic                 ready_q, ready_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [7:0]           in_port_q, in_port_d;
`ifdef M_FREQ_METER_IRQ_EN
  logic                 irq_q, irq_d;
`endif

  logic                 edge_c;
  logic                 sat_c;
  logic [CNT_WIDTH-1:0] cnt_next_c;
  logic [8:0]           off_c;
  logic                 hit_c;
  logic [1:0]           sel_c;
  logic                 rd_c;
  logic [23:0]          result_ext_c;

  // Address offset computed 9 bits wide so addresses below BASE never alias
  assign off_c        = {1'b0, bus.port_id} - {1'b0, BASE};
  assign hit_c        = (off_c < 9'd4);
  assign sel_c        = off_c[1:0];
  assign rd_c         = bus.read_strobe & hit_c;
  assign result_ext_c = 24'(result_q);
  assign edge_c       = sync2_q & ~hist_q;
  assign sat_c        = edge_c & (count_q == CNT_MAX);
  assign cnt_next_c   = sat_c ? count_q : count_q + CNT_WIDTH'(edge_c);
  assign bus.in_port  = in_port_q;
`ifdef M_FREQ_METER_IRQ_EN
  assign INTERRUPT    = irq_q;
`endif

  // Two-flop synchronizer plus edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= SIGNAL;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state, gate counting, register-map reads; window end overrides read clears
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timer_d    = timer_q;
    ovf_pend_d = ovf_pend_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    ready_d    = ready_q;
    shadow_d   = shadow_q;
    in_port_d  = 8'h00;
`ifdef M_FREQ_METER_IRQ_EN
    irq_d      = irq_q;
    if (interrupt_ack) irq_d = 1'b0;
`endif

    if (hit_c) begin
      case (sel_c)
        2'd0:    in_port_d = result_ext_c[7:0];
        2'd1:    in_port_d = shadow_q[7:0];
        2'd2:    in_port_d = shadow_q[15:8];
        default: in_port_d = {5'b0, (state_q == S_GATE), ovf_q, ready_q};
      endcase
    end

    if (rd_c && (sel_c == 2'd0)) shadow_d = result_ext_c[23:8];
    if (rd_c && (sel_c == 2'd2)) begin
      ready_d = 1'b0;
      ovf_d   = 1'b0;
`ifdef M_FREQ_METER_IRQ_EN
      irq_d   = 1'b0;
`endif
    end

    case (state_q)
      S_IDLE: begin
        count_d    = '0;
        timer_d    = '0;
        ovf_pend_d = 1'b0;
        if (ENABLE) state_d = S_GATE;
      end
      S_GATE: begin
        if (!ENABLE) begin
          state_d    = S_IDLE;
          count_d    = '0;
          timer_d    = '0;
          ovf_pend_d = 1'b0;
        end else if (timer_q == TMR_LAST) begin
          result_d   = cnt_next_c;
          ovf_d      = ovf_pend_q | sat_c;
          ready_d    = 1'b1;
          count_d    = '0;
          timer_d    = '0;
          ovf_pend_d = 1'b0;
`ifdef M_FREQ_METER_IRQ_EN
          irq_d      = 1'b1;
`endif
        end else begin
          timer_d    = timer_q + TMR_W'(1);
          count_d    = cnt_next_c;
          ovf_pend_d = ovf_pend_q | sat_c;
        end
      end
    endcase
  end

  // Datapath and register-map registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      timer_q    <= '0;
      ovf_pend_q <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
      shadow_q   <= '0;
      in_port_q  <= 8'h00;
`ifdef M_FREQ_METER_IRQ_EN
      irq_q      <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      timer_q    <= timer_d;
      ovf_pend_q <= ovf_pend_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
      shadow_q   <= shadow_d;
      in_port_q  <= in_port_d;
`ifdef M_FREQ_METER_IRQ_EN
      irq_q      <= irq_d;
`endif
    end
  end

endmodule

// File: doc/m_freq_meter.md
Name: m_freq_meter

Overview:
- Frequency meter peripheral, read side of the processor port bus.
- Counts rising edges of an external asynchronous SIGNAL over a fixed gate window of GATE_CYCLES clk cycles.
- Latches each window's count into a result register; the processor reads it back byte-wise through in_port.
- Sits alongside the port-write-configured clock/divider blocks. Used to measure trigger and external clock rates.

Parameters:
- BASE, 0: first port address; block occupies BASE+0..BASE+3.
- GATE_CYCLES, 1000000: gate window length in clk cycles; must be ≥2.
- CNT_WIDTH, 24: edge counter width, 8..24. Result bits above CNT_WIDTH read as 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- port_id  in  8  processor port address.
- read_strobe  in  1  one-clk pulse, processor has consumed the addressed byte.
- in_port  out  8  registered read data; 0x00 when port_id is outside BASE..BASE+3.
- SIGNAL  in  1  asynchronous input being measured.
- ENABLE  in  1  high = measuring, low = idle.

Behaviour:
- Reset values:
  - in_port=0x00, result=0, shadow=0, count=0, gate timer=0.
  - ready=0, ovf=0, ovf_pending=0, state=IDLE.
  - Sync flops=0, edge-detect history=0.
- SIGNAL path: 2-flop synchronizer, then rising-edge detect (history flop). Edge pulse is 1 clk, 3 clk after the input transition. Maximum countable rate is one edge per 2 clk.
- State IDLE:
  - count=0, timer=0.
  - ENABLE=1 → GATE on next clk.
- State GATE, each clk:
  - timer+1.
  - On an edge pulse, count+1. If count is already all-ones at CNT_WIDTH, count saturates and ovf_pending is set.
- End of window, in the cycle timer==GATE_CYCLES-1:
  - result <= count plus that cycle's edge, saturating.
  - ovf <= ovf_pending or saturation in that cycle.
  - ready <= 1; count, timer and ovf_pending cleared.
  - Stays in GATE: back-to-back windows, no dead cycles, no lost edges.
- ENABLE=0 during GATE: → IDLE next clk, partial window discarded. result, ready and ovf keep their values.
- Register map (in_port = registered decode of port_id, 1 clk latency):
  - BASE+0: result[7:0]. Also loads shadow <= result[23:8], so a multi-byte read is coherent.
  - BASE+1: shadow[7:0].
  - BASE+2: shadow[15:8].
  - BASE+3: status {5'b0, state==GATE, ovf, ready}.
- Side effects occur only on read_strobe=1 with a matching port_id:
  - Read BASE+0 → shadow load.
  - Read BASE+2 → ready and ovf cleared.
- If a window ends in the same clk as a clearing read of BASE+2: the window-end set wins, ready stays 1 and ovf takes the new value.
- If a window ends in the same clk as a BASE+0 read: shadow takes the old result, matching the byte 0 just returned.
- Reset mid-window: everything returns to reset values and the partial count is lost.
- Count arithmetic is unsigned. The timer is wide enough for GATE_CYCLES-1 and never wraps.

Optional Feature:
- Macro M_FREQ_METER_IRQ_EN.
- When defined:
  - Adds output INTERRUPT (1 bit, reset 0) and input interrupt_ack (1 bit).
  - INTERRUPT is set in the clk after each window-end latch.
  - INTERRUPT is cleared by interrupt_ack=1 or by the BASE+2 clearing read. A same-cycle window end overrides the clear.
- When not defined: neither port exists, and behaviour is identical otherwise.

Test Plan:
- GATE_CYCLES=100, SIGNAL period 10 clk, ENABLE=1 → after 2 windows, reading BASE+3 gives 0x05; reading BASE+0/1/2 gives 0x0A/0x00/0x00; status after the BASE+2 read is 0x04.
- CNT_WIDTH=8, GATE_CYCLES=1000, SIGNAL period 2 clk (500 edges) → result 0xFF, status 0x07; BASE+1 and BASE+2 read 0x00.
- Reset values: after reset, reading BASE+0..BASE+3 gives 0x00 each; port_id=BASE+4 gives in_port 0x00.
- GATE_CYCLES=100, SIGNAL period 4 clk → first window result 0x19 with ready=1; drop ENABLE at timer=50 → status 0x01, result still 0x19; re-raise ENABLE → next result 0x19 exactly 101 clk later.
- Coherency and collision: read BASE+0 (0x19), let a window with count 0x21 end, then read BASE+1/2 → shadow bytes belong to 0x19. Also issue the BASE+2 clearing read in the window-end cycle → ready remains 1.
- With M_FREQ_METER_IRQ_EN, GATE_CYCLES=50: INTERRUPT rises 1 clk after the window end; a pulse on interrupt_ack clears it next clk; the next window sets it again.
